// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer in front of a single-port synchronous memory, with read-modify-write for sh/sb.
// Latency: load 2+MEM_LAT, sh/sb 3+MEM_LAT, sw 2, illegal op 1; req is ignored while busy is high (no queueing).
module mem_access_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] OP_LW = 3'b001;
   localparam logic [2:0] OP_LH = 3'b010;
   localparam logic [2:0] OP_LB = 3'b011;
   localparam logic [2:0] OP_SW = 3'b100;
   localparam logic [2:0] OP_SH = 3'b101;
   localparam logic [2:0] OP_SB = 3'b110;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WRITE    = 3'd3,
      DONE     = 3'd4
   } state_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   state_t      state_q, state_d;
   req_t        req_q, req_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_wr_q, mem_wr_d;

   function automatic logic is_load(input logic [2:0] o);
      return (o == OP_LW) || (o == OP_LH) || (o == OP_LB);
   endfunction

   function automatic logic is_sub_store(input logic [2:0] o);
      return (o == OP_SH) || (o == OP_SB);
   endfunction

   // Sub-word lanes are always the low lane; the address never selects a lane.
   function automatic logic [31:0] load_ext(input logic [2:0] o, input logic [31:0] w);
      logic [31:0] r;
      r = w;
      if (o == OP_LH) begin
         r = {16'b0, w[15:0]};
      end else if (o == OP_LB) begin
         r = {24'b0, w[7:0]};
      end
      return r;
   endfunction

   function automatic logic [31:0] merge_store(input logic [2:0] o, input logic [31:0] w,
                                               input logic [31:0] d);
      logic [31:0] r;
      r = d;
      if (o == OP_SH) begin
         r = {w[31:16], d[15:0]};
      end else if (o == OP_SB) begin
         r = {w[31:8], d[7:0]};
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               req_d = '{op: op, addr: addr, wdata: wdata};
               if (is_load(op) || is_sub_store(op)) begin
                  state_d    = RD_ISSUE;
                  mem_addr_d = addr;
               end else if (op == OP_SW) begin
                  state_d     = WRITE;
                  mem_addr_d  = addr;
                  mem_wdata_d = wdata;
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
         end
         RD_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            // Memory data is valid in the cycle where the count has run down to zero.
            if (cnt_q == 4'd0) begin
               word_d = mem_rdata;
               if (is_sub_store(req_q.op)) begin
                  state_d     = WRITE;
                  mem_addr_d  = req_q.addr;
                  mem_wdata_d = merge_store(req_q.op, mem_rdata, req_q.wdata);
               end else begin
                  state_d = DONE;
                  rdata_d = load_ext(req_q.op, mem_rdata);
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WRITE: begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Strobes are registered copies of the next-state decode, so they align with the state.
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      mem_rd_d = (state_d == RD_ISSUE);
      mem_wr_d = (state_d == WRITE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         cnt_q       <= 4'd0;
         word_q      <= 32'd0;
         rdata_q     <= 32'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with MEM_LAT=2 and a small behavioural memory model.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        busy, done, err, mem_rd, mem_wr;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:255];
   logic        preload = 1'b0;
   logic        v1, v2;
   logic [31:0] p1, p2;

   int n_cmp = 0;
   int n_err = 0;

   int          rd_cyc, wr_cyc, done_cyc, n_rd, n_wr;
   logic        err_v, both_v, gap_v, busy_after;
   logic [31:0] wr_dat, rdata_v;
   logic [15:0] rd_mask, done_mask;
   logic        wr_seen;

   always #5 clk = ~clk;

   mem_access_ctrl #(.MEM_LAT(2)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (preload) begin
         mem[8'h40] <= 32'hDEADBEEF;
      end else if (mem_wr) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   // Two-stage read pipe: data is driven only in the single cycle it is valid.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0; v2 <= 1'b0; p1 <= 32'd0; p2 <= 32'd0;
      end else begin
         v1 <= mem_rd; v2 <= v1;
         p1 <= mem[mem_addr[7:0]]; p2 <= p1;
      end
   end
   assign mem_rdata = v2 ? p2 : 32'h0BAD0BAD;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request in cycle 0 and record strobe cycles up to done.
   task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
      int cyc;
      req = 1'b1; op = o; addr = a; wdata = d;
      rd_cyc = -1; wr_cyc = -1; done_cyc = -1; n_rd = 0; n_wr = 0;
      err_v = 1'b0; both_v = 1'b0; gap_v = 1'b0; wr_dat = 32'd0; rdata_v = 32'd0;
      tick();
      req = 1'b0;
      cyc = 1;
      for (int k = 0; k < 20; k++) begin
         if (mem_rd) begin rd_cyc = cyc; n_rd++; end
         if (mem_wr) begin wr_cyc = cyc; wr_dat = mem_wdata; n_wr++; end
         if (mem_rd && mem_wr) both_v = 1'b1;
         if (!busy) gap_v = 1'b1;
         if (done) begin
            done_cyc = cyc; err_v = err; rdata_v = rdata;
            break;
         end
         tick();
         cyc++;
      end
      tick();
      busy_after = busy;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_busy"}, 32'(busy), 32'd0);
      check({pfx, "_done"}, 32'(done), 32'd0);
      check({pfx, "_err"}, 32'(err), 32'd0);
      check({pfx, "_mem_rd"}, 32'(mem_rd), 32'd0);
      check({pfx, "_mem_wr"}, 32'(mem_wr), 32'd0);
      check({pfx, "_rdata"}, rdata, 32'd0);
      check({pfx, "_mem_addr"}, mem_addr, 32'd0);
      check({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      preload = 1'b1;
      tick();
      preload = 1'b0;
      tick();
      check_reset_outputs("rst");
      reset = 1'b0;
      tick();

      // lw 0x40
      run(3'b001, 32'h40, 32'd0);
      check("lw_rd_cyc", 32'(rd_cyc), 32'd1);
      check("lw_done_cyc", 32'(done_cyc), 32'd4);
      check("lw_rdata", rdata_v, 32'hDEADBEEF);
      check("lw_n_wr", 32'(n_wr), 32'd0);
      check("lw_n_rd", 32'(n_rd), 32'd1);
      check("lw_err", 32'(err_v), 32'd0);
      check("lw_busy_gap", 32'(gap_v), 32'd0);
      check("lw_busy_after", 32'(busy_after), 32'd0);

      // lh then lb
      run(3'b010, 32'h40, 32'd0);
      check("lh_rdata", rdata_v, 32'h0000BEEF);
      check("lh_done_cyc", 32'(done_cyc), 32'd4);
      run(3'b011, 32'h40, 32'd0);
      check("lb_rdata", rdata_v, 32'h000000EF);

      // sh then sb read-modify-write
      run(3'b101, 32'h40, 32'h12345678);
      check("sh_rd_cyc", 32'(rd_cyc), 32'd1);
      check("sh_wr_cyc", 32'(wr_cyc), 32'd4);
      check("sh_wdata", wr_dat, 32'hDEAD5678);
      check("sh_done_cyc", 32'(done_cyc), 32'd5);
      check("sh_both", 32'(both_v), 32'd0);
      check("sh_rdata_hold", rdata, 32'h000000EF);
      run(3'b110, 32'h40, 32'hAABBCC99);
      check("sb_wdata", wr_dat, 32'hDEAD5699);
      check("sb_wr_cyc", 32'(wr_cyc), 32'd4);

      // sw then lw readback
      run(3'b100, 32'h40, 32'hCAFEF00D);
      check("sw_wr_cyc", 32'(wr_cyc), 32'd1);
      check("sw_wdata", wr_dat, 32'hCAFEF00D);
      check("sw_done_cyc", 32'(done_cyc), 32'd2);
      check("sw_n_rd", 32'(n_rd), 32'd0);
      run(3'b001, 32'h40, 32'd0);
      check("sw_lw_rdata", rdata_v, 32'hCAFEF00D);

      // illegal ops
      run(3'b000, 32'h40, 32'h11111111);
      check("op000_done_cyc", 32'(done_cyc), 32'd1);
      check("op000_err", 32'(err_v), 32'd1);
      check("op000_strobes", 32'(n_rd + n_wr), 32'd0);
      check("op000_rdata", rdata_v, 32'hCAFEF00D);
      run(3'b111, 32'h40, 32'h22222222);
      check("op111_done_cyc", 32'(done_cyc), 32'd1);
      check("op111_err", 32'(err_v), 32'd1);
      check("op111_strobes", 32'(n_rd + n_wr), 32'd0);
      check("op111_rdata", rdata_v, 32'hCAFEF00D);

      // req held high across busy lw: one acceptance per completion
      rd_mask = 16'd0; done_mask = 16'd0;
      req = 1'b1; op = 3'b001; addr = 32'h40; wdata = 32'd0;
      tick();
      for (int c = 1; c <= 9; c++) begin
         if (mem_rd) rd_mask[c] = 1'b1;
         if (done) done_mask[c] = 1'b1;
         if (c == 9) req = 1'b0;
         tick();
      end
      check("hold_rd_mask", 32'(rd_mask), 32'h0042);
      check("hold_done_mask", 32'(done_mask), 32'h0210);
      tick();
      check("hold_idle", 32'(busy), 32'd0);

      // async reset during RD_WAIT of sb
      req = 1'b1; op = 3'b110; addr = 32'h40; wdata = 32'h11223344;
      tick();
      req = 1'b0;
      tick();
      check("rw_busy_before", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("arst");
      wr_seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (mem_wr) wr_seen = 1'b1;
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (mem_wr) wr_seen = 1'b1;
      end
      check("arst_no_wr", 32'(wr_seen), 32'd0);
      run(3'b001, 32'h40, 32'd0);
      check("post_rst_done_cyc", 32'(done_cyc), 32'd4);
      check("post_rst_rdata", rdata_v, 32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multicycle memory-access sequencer sitting between the CPU control unit and the single-port synchronous data memory. It accepts one load/store request at a time and issues the memory read and/or write cycles. For sub-word stores it performs the read-modify-write sequence itself, and it returns zero-extended load data. It also owns the wait-state counting for the memory read latency, so the control FSM only has to watch `busy`/`done`.

## Interface
- `MEM_LAT`, default 1: memory read latency in cycles, legal range 1..15.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; sampled only while `busy`=0.
- `op`  in  3  001 lw, 010 lh, 011 lb, 100 sw, 101 sh, 110 sb; 000 and 111 are illegal.
- `addr`  in  32  word address, passed to memory unmodified.
- `wdata`  in  32  store data (B register).
- `busy`  out  1  high while a request is in flight, through the `done` cycle inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, for an illegal `op`.
- `rdata`  out  32  load result; holds its value until the next load completes.
- `mem_addr`  out  32  memory address.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_wr`  out  1  one-cycle write strobe.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid `MEM_LAT` cycles after the `mem_rd` cycle.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WRITE, DONE. `busy` = (state != IDLE).
- In IDLE with `req`=1, latch `op`, `addr`, `wdata`, then branch:
  - Loads go to RD_ISSUE, then RD_WAIT, then DONE.
  - sw goes to WRITE, then DONE.
  - sh and sb go to RD_ISSUE, then RD_WAIT, then WRITE, then DONE.
  - Illegal op goes to DONE with `err`=1.
- RD_ISSUE: `mem_rd`=1 and `mem_addr` = latched addr; the wait counter is loaded with `MEM_LAT`-1.
- RD_WAIT: the counter decrements each cycle. When it reaches 0, capture `mem_rdata` into the internal word register, then move on.
- Load result, assigned in DONE:
  - lw: word.
  - lh: {16'b0, word[15:0]}.
  - lb: {24'b0, word[7:0]}.
  - Halfword and byte are always the low lane of the word; `addr[1:0]` is not used for lane selection.
- WRITE: `mem_wr`=1, `mem_addr` = latched addr, and `mem_wdata` is:
  - sw: wdata.
  - sh: {word[31:16], wdata[15:0]}.
  - sb: {word[31:8], wdata[7:0]}.
- DONE: `done`=1 for one cycle, then return to IDLE. `rdata` updates only for a legal load.
- `req` while `busy`=1 is ignored. A new request is accepted in the first IDLE cycle after DONE.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- Reset, at any time, takes effect asynchronously:
  - state = IDLE.
  - `busy`, `done`, `err`, `mem_rd`, `mem_wr` = 0.
  - `rdata`, `mem_addr`, `mem_wdata`, internal word and counter = 0.
  - An in-flight read is discarded and a pending WRITE is never issued.

## Timing
- Cycle 0 is the cycle with `req`=1 and `busy`=0. All outputs are registered.
- Loads, sh and sb:
  - `mem_rd` in cycle 1.
  - `mem_rdata` captured at the end of cycle 1+`MEM_LAT`.
- Load: `done` and valid `rdata` in cycle 2+`MEM_LAT`; total latency 2+`MEM_LAT`.
- sh/sb: `mem_wr` in cycle 2+`MEM_LAT`, `done` in cycle 3+`MEM_LAT`.
- sw: `mem_wr` in cycle 1, `done` in cycle 2.
- Illegal op: `done`+`err` in cycle 1, with no memory strobe.
- `busy` is high from cycle 1 through the `done` cycle. Earliest back-to-back acceptance is the cycle after `done`.
- With `MEM_LAT`=1, RD_WAIT lasts exactly one cycle. The counter never underflows.

## Test plan
All scenarios use `MEM_LAT`=2 and memory word 0x40 = 0xDEADBEEF.
- lw, addr 0x40: `mem_rd` in cycle 1 -> `done` in cycle 4, `rdata`=0xDEADBEEF, `mem_wr` never asserted.
- lh, then lb, addr 0x40: `rdata`=0x0000BEEF at the first `done`, then `rdata`=0x000000EF at the second `done`.
- sh with wdata=0x12345678: `mem_wr` in cycle 4 with `mem_wdata`=0xDEAD5678 -> `done` in cycle 5. A following sb with wdata=0xAABBCC99 writes 0xDEAD5699.
- sw with wdata=0xCAFEF00D: `mem_wr` in cycle 1 with 0xCAFEF00D, `done` in cycle 2. A subsequent lw returns 0xCAFEF00D.
- op=000 and op=111: `done`=`err`=1 in cycle 1, no `mem_rd`/`mem_wr`, `rdata` unchanged. `req` held high throughout a busy lw is accepted only once per completion.
- Reset asserted mid-cycle during RD_WAIT of an sb: all outputs go to 0 immediately with no `mem_wr`. After reset release, a lw completes normally in cycle 4.
